// File: rtl/device_bus_if.sv
// CPU-side memory port of the device bus controller: access strobe,
// write qualifier, address/data in, and registered completion status out.
interface device_bus_if;
  logic        req;
  logic        write_enable;
  logic [15:0] address;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        done;
  logic        error;
  logic        busy;

  modport master (
    output req, write_enable, address, data_in,
    input  data_out, done, error, busy
  );

  modport slave (
    input  req, write_enable, address, data_in,
    output data_out, done, error, busy
  );
endinterface

// File: rtl/device_bus.sv
// Device bus controller: decodes a target from the CPU address, runs a
// select/ready handshake with a slot peripheral (bounded by a timeout),
// serves the internal interrupt-pending register, and reports done/error.
module device_bus #(
  parameter int unsigned N_DEVICES   = 4,
  parameter logic [7:0]  DEVICE_BASE = 8'h02,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  device_bus_if.slave              bus,
  output logic [N_DEVICES-1:0]     dev_select,
  output logic                     dev_write,
  output logic                     dev_control,
  output logic [7:0]               dev_address,
  output logic [15:0]              dev_data_in,
  input  logic [16*N_DEVICES-1:0]  dev_data_out,
  input  logic [N_DEVICES-1:0]     dev_ready,
  input  logic [N_DEVICES-1:0]     dev_irq,
  output logic                     irq,
  output logic [N_DEVICES-1:0]     irq_pending
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [8:0]  BASE9    = {1'b0, DEVICE_BASE};
  localparam logic [8:0]  LIMIT9   = BASE9 + 9'(N_DEVICES);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [15:0]          count_q;
  logic [3:0]           slot_idx_q;
  logic [15:0]          dout_q;
  logic                 err_q;

  logic                 req_ctrl;
  logic [7:0]           req_target;
  logic                 req_internal;
  logic                 req_slot;
  logic [3:0]           req_idx;
  logic [N_DEVICES-1:0] req_onehot;
  logic [15:0]          slot_rdata;
  logic [N_DEVICES-1:0] irq_clear;
  logic [N_DEVICES-1:0] pending_d;

  logic                 start_access;
  logic                 internal_op;
  logic                 unmapped_op;
  logic                 access_ok;
  logic                 access_to;

  assign bus.data_out = dout_q;
  assign bus.error    = err_q;
  assign bus.done     = (state_q == RESP);
  assign bus.busy     = (state_q != IDLE);

  // Target decode. The IDLE->ACCESS/RESP choice is made on the edge that
  // latches the address, so decoding the incoming address here yields the
  // same result as decoding the latched copy one cycle later.
  always_comb begin
    req_ctrl     = (bus.address[15:12] == 4'h0);
    req_target   = req_ctrl ? bus.address[11:4] : bus.address[15:8];
    req_internal = (req_target == 8'h00);
    req_slot     = !req_internal &&
                   ({1'b0, req_target} >= BASE9) &&
                   ({1'b0, req_target} <  LIMIT9);
    req_idx      = req_target[3:0] - DEVICE_BASE[3:0];
    req_onehot   = '0;
    for (int unsigned i = 0; i < N_DEVICES; i++) begin
      req_onehot[i] = (req_idx == 4'(i));
    end
  end

  // Read data of the slot currently being accessed.
  always_comb begin
    slot_rdata = '0;
    for (int unsigned i = 0; i < N_DEVICES; i++) begin
      if (slot_idx_q == 4'(i)) begin
        slot_rdata = dev_data_out[16*i +: 16];
      end
    end
  end

  // Next-state and one-cycle action strobes for the access sequencer.
  always_comb begin
    state_d      = state_q;
    start_access = 1'b0;
    internal_op  = 1'b0;
    unmapped_op  = 1'b0;
    access_ok    = 1'b0;
    access_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (req_slot) begin
            state_d      = ACCESS;
            start_access = 1'b1;
          end else begin
            state_d = RESP;
            if (req_internal) internal_op = 1'b1;
            else              unmapped_op = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (|(dev_ready & dev_select)) begin
          state_d   = RESP;
          access_ok = 1'b1;
        end else if (count_q == CNT_LAST) begin
          state_d   = RESP;
          access_to = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Interrupt pending update: a set in the same cycle as a clear wins.
  always_comb begin
    irq_clear = '0;
    if (internal_op && bus.write_enable) begin
      irq_clear = bus.data_in[N_DEVICES-1:0];
    end
    pending_d = (irq_pending & ~irq_clear) | dev_irq;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: latched request fields, slot select, timeout counter,
  // response data/status and interrupt registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      dev_select  <= '0;
      dev_write   <= 1'b0;
      dev_control <= 1'b0;
      dev_address <= '0;
      dev_data_in <= '0;
      slot_idx_q  <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      err_q       <= 1'b0;
      irq_pending <= '0;
      irq         <= 1'b0;
    end else begin
      irq_pending <= pending_d;
      irq         <= |pending_d;

      if (state_q == IDLE && bus.req) begin
        dev_write   <= bus.write_enable;
        dev_control <= req_ctrl;
        dev_address <= bus.address[7:0];
        dev_data_in <= bus.data_in;
        slot_idx_q  <= req_idx;
      end

      if (start_access) begin
        dev_select <= req_onehot;
        count_q    <= '0;
      end else if (state_q == ACCESS && state_d == ACCESS) begin
        count_q <= count_q + 16'd1;
      end

      if (access_ok) begin
        dev_select <= '0;
        err_q      <= 1'b0;
        if (!dev_write) dout_q <= slot_rdata;
      end

      if (access_to) begin
        dev_select <= '0;
        err_q      <= 1'b1;
        dout_q     <= '0;
      end

      if (internal_op) begin
        err_q <= 1'b0;
        if (!bus.write_enable) dout_q <= 16'(irq_pending);
      end

      if (unmapped_op) begin
        err_q  <= 1'b1;
        dout_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_device_bus.sv
// Bench for device_bus: table of accesses driven through the CPU port,
// expected completions queued at drive time and checked when done pulses,
// plus hand-written interrupt and mid-access reset sequences.
module tb_device_bus;

  localparam int N    = 4;
  localparam int BASE = 2;
  localparam int TO   = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     dev_select;
  logic             dev_write;
  logic             dev_control;
  logic [7:0]       dev_address;
  logic [15:0]      dev_data_in;
  logic [16*N-1:0]  dev_data_out = '0;
  logic [N-1:0]     dev_ready = '0;
  logic [N-1:0]     dev_irq = '0;
  logic             irq;
  logic [N-1:0]     irq_pending;

  device_bus_if bus ();

  device_bus #(
    .N_DEVICES  (N),
    .DEVICE_BASE(8'h02),
    .TIMEOUT    (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dev_select  (dev_select),
    .dev_write   (dev_write),
    .dev_control (dev_control),
    .dev_address (dev_address),
    .dev_data_in (dev_data_in),
    .dev_data_out(dev_data_out),
    .dev_ready   (dev_ready),
    .dev_irq     (dev_irq),
    .irq         (irq),
    .irq_pending (irq_pending)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          rdy;        // negedges after req before ready; -1 never
    logic [15:0] data;       // slot read data, or expected internal read value
    logic        exp_err;
    int          lat;        // cycles from req to done
    logic        hold_req;
    logic        others_rdy;
  } vec_t;

  typedef struct {
    logic        err;
    logic [15:0] data;
    int          at;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_dout = '0;
  vec_t        vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] exp_sel(input logic [15:0] a);
    logic [N-1:0] s;
    int t;
    s = '0;
    t = (a[15:12] == 4'h0) ? int'(a[11:4]) : int'(a[15:8]);
    for (int i = 0; i < N; i++) begin
      if (t == BASE + i) s[i] = 1'b1;
    end
    return s;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("error", bus.error, e.err);
        chk("data_out", bus.data_out, e.data);
        chk("done_cycle", cyc, e.at);
        chk("busy_at_done", bus.busy, 1'b1);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    logic [N-1:0] sel;
    logic [15:0]  ed;
    logic         ctrl;
    int           sel_cyc;
    bit           seen;
    sel  = exp_sel(v.addr);
    ctrl = (v.addr[15:12] == 4'h0);
    @(negedge clock);
    bus.req          = 1'b1;
    bus.write_enable = v.we;
    bus.address      = v.addr;
    bus.data_in      = v.wdata;
    for (int i = 0; i < N; i++) begin
      dev_data_out[16*i +: 16] = sel[i] ? v.data : (16'hDEA0 + 16'(i));
    end
    dev_ready = v.others_rdy ? ~sel : '0;
    if (v.rdy == 0) dev_ready = dev_ready | sel;
    if (v.exp_err)  ed = '0;
    else if (!v.we) ed = v.data;
    else            ed = model_dout;
    model_dout = ed;
    sb_q.push_back('{v.exp_err, ed, cyc + v.lat});
    seen    = 1'b0;
    sel_cyc = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clock);
      if (!(v.hold_req && n <= 5)) bus.req = 1'b0;
      if (v.rdy > 0 && n == v.rdy) dev_ready = dev_ready | sel;
      if (bus.done) begin
        seen = 1'b1;
      end else if (dev_select != '0) begin
        sel_cyc++;
        chk("dev_select_onehot", dev_select, sel);
      end
    end
    bus.req = 1'b0;
    chk("done_within_bound", seen, 1'b1);
    chk("select_cycles", sel_cyc, (sel != '0) ? v.lat - 1 : 0);
    chk("select_dropped", dev_select, '0);
    chk("dev_write", dev_write, v.we);
    chk("dev_control", dev_control, ctrl);
    chk("dev_data_in", dev_data_in, v.wdata);
    if (!ctrl) chk("dev_address", dev_address, v.addr[7:0]);
    dev_ready = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //         addr    we    wdata    rdy data     err  lat hold others
    vt[0]  = '{16'h0000, 1'b0, 16'h0000, -1, 16'h0000, 1'b0, 1,  1'b0, 1'b0};
    vt[1]  = '{16'h0027, 1'b0, 16'h0000,  0, 16'hBEEF, 1'b0, 2,  1'b0, 1'b0};
    vt[2]  = '{16'h0035, 1'b1, 16'h1234,  4, 16'h0000, 1'b0, 5,  1'b0, 1'b0};
    vt[3]  = '{16'h0900, 1'b0, 16'h0000, -1, 16'h0000, 1'b1, 1,  1'b0, 1'b0};
    vt[4]  = '{16'h0058, 1'b0, 16'h0000,  1, 16'h5A5A, 1'b0, 2,  1'b0, 1'b0};
    vt[5]  = '{16'h0060, 1'b0, 16'h0000, -1, 16'h0000, 1'b1, 1,  1'b0, 1'b0};
    vt[6]  = '{16'h0010, 1'b0, 16'h0000, -1, 16'h0000, 1'b1, 1,  1'b0, 1'b0};
    vt[7]  = '{16'h0200, 1'b0, 16'h0000, -1, 16'h0000, 1'b1, 1,  1'b0, 1'b0};
    vt[8]  = '{16'h0031, 1'b0, 16'h0000,  2, 16'hC0DE, 1'b0, 3,  1'b0, 1'b0};
    vt[9]  = '{16'h1200, 1'b1, 16'h7777, -1, 16'h0000, 1'b1, 1,  1'b0, 1'b0};
    vt[10] = '{16'h0044, 1'b0, 16'h0000, -1, 16'h0000, 1'b1, 17, 1'b1, 1'b1};
    vt[11] = '{16'h0030, 1'b0, 16'h0000,  0, 16'h1111, 1'b0, 2,  1'b0, 1'b0};
    vt[12] = '{16'h0042, 1'b1, 16'h4242,  3, 16'h0000, 1'b0, 4,  1'b0, 1'b0};
    vt[13] = '{16'hF300, 1'b0, 16'h0000, -1, 16'h0000, 1'b1, 1,  1'b0, 1'b0};

    bus.req          = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = '0;
    bus.data_in      = '0;
    reset            = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_error", bus.error, 1'b0);
    chk("rst_data_out", bus.data_out, 16'h0000);
    chk("rst_dev_select", dev_select, '0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_irq_pending", irq_pending, '0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vt[i]);

    // Interrupt pending: set, read back, clear blocked by live level, clear.
    @(negedge clock);
    dev_irq = 4'b1000;
    @(negedge clock);
    dev_irq = '0;
    @(negedge clock);
    chk("irq_pending_set", irq_pending, 4'b1000);
    chk("irq_set", irq, 1'b1);
    run_vec('{16'h0000, 1'b0, 16'h0000, -1, 16'h0008, 1'b0, 1, 1'b0, 1'b0});
    dev_irq = 4'b1000;
    run_vec('{16'h0000, 1'b1, 16'h0008, -1, 16'h0000, 1'b0, 1, 1'b0, 1'b0});
    chk("irq_set_wins", irq_pending, 4'b1000);
    chk("irq_still_high", irq, 1'b1);
    dev_irq = '0;
    run_vec('{16'h0000, 1'b1, 16'h0008, -1, 16'h0000, 1'b0, 1, 1'b0, 1'b0});
    @(negedge clock);
    chk("irq_pending_cleared", irq_pending, '0);
    chk("irq_cleared", irq, 1'b0);

    // Reset in the middle of a slot access.
    @(negedge clock);
    bus.req          = 1'b1;
    bus.write_enable = 1'b0;
    bus.address      = 16'h0044;
    bus.data_in      = 16'h0000;
    @(negedge clock);
    bus.req = 1'b0;
    chk("mid_select", dev_select, 4'b0100);
    chk("mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("mr_busy", bus.busy, 1'b0);
    chk("mr_select", dev_select, '0);
    chk("mr_done", bus.done, 1'b0);
    chk("mr_data_out", bus.data_out, 16'h0000);
    chk("mr_dev_address", dev_address, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("mr_no_done", bus.done, 1'b0);
    end

    @(negedge clock);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
